// File: rtl/block_tile_scheduler.sv
// Tile/slice sequencer for C = A x B: per slice it launches the block multiplier, waits for it, then launches the block adder.
// Define BLOCK_SCHED_PERF_EN to add the perf_cycles / perf_stall counters.
`timescale 1ns/1ps
module block_tile_scheduler #(
    parameter int ROW_TILE   = 2,
    parameter int COL_TILE   = 2,
    parameter int INNER_TILE = 2,
    parameter int DIM_W      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] m_rows,
    input  logic [DIM_W-1:0] n_cols,
    input  logic [DIM_W-1:0] k_inner,
    output logic             busy,
    output logic             done,
    output logic             mul_start,
    output logic [DIM_W-1:0] mul_row,
    output logic [DIM_W-1:0] mul_col,
    output logic [DIM_W-1:0] mul_k,
    input  logic             mul_done,
    output logic             add_start,
    output logic [DIM_W-1:0] add_row,
    output logic [DIM_W-1:0] add_col,
    output logic [DIM_W-1:0] add_num_cols
`ifdef BLOCK_SCHED_PERF_EN
    ,
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_stall
`endif
);

    localparam int CW = DIM_W + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE_MUL = 3'd1,
        WAIT_MUL  = 3'd2,
        ADD       = 3'd3,
        NEXT      = 3'd4,
        FINISH    = 3'd5
    } state_t;

    state_t         state_reg;
    state_t         state_next;

    logic [CW-1:0]  m_reg;
    logic [CW-1:0]  n_reg;
    logic [CW-1:0]  k_reg;
    logic [CW-1:0]  row_reg;
    logic [CW-1:0]  row_next;
    logic [CW-1:0]  col_reg;
    logic [CW-1:0]  col_next;
    logic [CW-1:0]  kk_reg;
    logic [CW-1:0]  kk_next;
    logic [CW-1:0]  row_sum;
    logic [CW-1:0]  col_sum;
    logic [CW-1:0]  kk_sum;

    logic           accept;
    logic           zero_dim;
    logic           busy_reg;
    logic           done_reg;
    logic           mul_start_reg;
    logic           add_start_reg;

    // One extra counter bit keeps origin + tile from wrapping before the compare.
    assign row_sum  = row_reg + CW'(ROW_TILE);
    assign col_sum  = col_reg + CW'(COL_TILE);
    assign kk_sum   = kk_reg + CW'(INNER_TILE);
    assign zero_dim = (m_rows == '0) || (n_cols == '0) || (k_inner == '0);

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        kk_next    = kk_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                // busy_reg is still high for the cycle after FINISH; start is ignored there.
                if (start && !busy_reg) begin
                    accept   = 1'b1;
                    row_next = '0;
                    col_next = '0;
                    kk_next  = '0;
                    state_next = zero_dim ? FINISH : ISSUE_MUL;
                end
            end
            ISSUE_MUL: state_next = WAIT_MUL;
            WAIT_MUL: begin
                if (mul_done) begin
                    state_next = ADD;
                end
            end
            ADD: state_next = NEXT;
            NEXT: begin
                state_next = ISSUE_MUL;
                if (kk_sum < k_reg) begin
                    kk_next = kk_sum;
                end else begin
                    kk_next = '0;
                    if (col_sum < n_reg) begin
                        col_next = col_sum;
                    end else begin
                        col_next = '0;
                        if (row_sum < m_reg) begin
                            row_next = row_sum;
                        end else begin
                            state_next = FINISH;
                        end
                    end
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            row_reg       <= '0;
            col_reg       <= '0;
            kk_reg        <= '0;
            m_reg         <= '0;
            n_reg         <= '0;
            k_reg         <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            mul_start_reg <= 1'b0;
            add_start_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            col_reg   <= col_next;
            kk_reg    <= kk_next;
            if (accept) begin
                m_reg <= {1'b0, m_rows};
                n_reg <= {1'b0, n_cols};
                k_reg <= {1'b0, k_inner};
            end
            mul_start_reg <= (state_next == ISSUE_MUL);
            add_start_reg <= (state_next == ADD);
            done_reg      <= (state_next == FINISH);
            // busy covers every non-IDLE cycle plus the cycle right after done.
            busy_reg      <= (state_next != IDLE) || (state_reg == FINISH);
        end
    end

    // Counters only move on leaving NEXT, so coordinates hold from ISSUE_MUL through ADD.
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign mul_start    = mul_start_reg;
    assign add_start    = add_start_reg;
    assign mul_row      = row_reg[DIM_W-1:0];
    assign mul_col      = col_reg[DIM_W-1:0];
    assign mul_k        = kk_reg[DIM_W-1:0];
    assign add_row      = row_reg[DIM_W-1:0];
    assign add_col      = col_reg[DIM_W-1:0];
    assign add_num_cols = n_reg[DIM_W-1:0];

`ifdef BLOCK_SCHED_PERF_EN
    logic [31:0] perf_cycles_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles_reg <= '0;
            perf_stall_reg  <= '0;
        end else if (accept) begin
            perf_cycles_reg <= '0;
            perf_stall_reg  <= '0;
        end else begin
            if (busy_reg && (perf_cycles_reg != '1)) begin
                perf_cycles_reg <= perf_cycles_reg + 32'd1;
            end
            if ((state_reg == WAIT_MUL) && !mul_done && (perf_stall_reg != '1)) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_reg;
    assign perf_stall  = perf_stall_reg;
`endif

endmodule

// File: tb/tb_block_tile_scheduler.sv
// Self-checking bench for block_tile_scheduler: directed and random products against a loop-nest reference model.
`timescale 1ns/1ps
module tb_block_tile_scheduler;

    localparam int DW = 10;
    localparam int RT = 2;
    localparam int CT = 2;
    localparam int IT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] m_rows;
    logic [DW-1:0] n_cols;
    logic [DW-1:0] k_inner;
    logic          busy;
    logic          done;
    logic          mul_start;
    logic [DW-1:0] mul_row;
    logic [DW-1:0] mul_col;
    logic [DW-1:0] mul_k;
    logic          mul_done;
    logic          add_start;
    logic [DW-1:0] add_row;
    logic [DW-1:0] add_col;
    logic [DW-1:0] add_num_cols;
`ifdef BLOCK_SCHED_PERF_EN
    logic [31:0]   perf_cycles;
    logic [31:0]   perf_stall;
`endif

    block_tile_scheduler #(
        .ROW_TILE(RT), .COL_TILE(CT), .INNER_TILE(IT), .DIM_W(DW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .m_rows(m_rows), .n_cols(n_cols), .k_inner(k_inner),
        .busy(busy), .done(done),
        .mul_start(mul_start), .mul_row(mul_row), .mul_col(mul_col), .mul_k(mul_k),
        .mul_done(mul_done),
        .add_start(add_start), .add_row(add_row), .add_col(add_col),
        .add_num_cols(add_num_cols)
`ifdef BLOCK_SCHED_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Multiplier stand-in: mul_done rises resp_delay cycles after mul_start, or is held high.
    int resp_delay = 2;
    bit resp_hold  = 1'b0;
    int resp_cd    = 0;
    always @(negedge clk) begin
        if (resp_hold) begin
            mul_done = 1'b1;
        end else begin
            mul_done = 1'b0;
            if (resp_cd > 0) begin
                resp_cd--;
                if (resp_cd == 0) mul_done = 1'b1;
            end
            if (mul_start) resp_cd = resp_delay;
        end
    end

    // Monitor: logs every pulse with its coordinates, all sampled mid-cycle.
    logic [3*DW-1:0] mul_q[$];
    logic [3*DW-1:0] add_q[$];
    int cyc       = 0;
    int done_cnt  = 0;
    int busy_cnt  = 0;
    int start_idx = 0;
    int done_idx  = 0;
    always @(negedge clk) begin
        cyc++;
        if (mul_start) mul_q.push_back({mul_row, mul_col, mul_k});
        if (add_start) add_q.push_back({add_row, add_col, add_num_cols});
        if (done) begin
            done_cnt++;
            done_idx = cyc;
        end
        if (busy) busy_cnt++;
        if (start && !busy && !rst) start_idx = cyc;
    end

    task automatic run(input string name, input int m, input int n, input int k,
                       input int d, input bit hold, input bit poke);
        int b_mul, b_add, b_done, b_busy, w, slices, guard;
        logic [3*DW-1:0] em[$];
        logic [3*DW-1:0] ea[$];
        logic [3*DW-1:0] obs;
        logic [DW-1:0] r_v, c_v, k_v, n_v;
        b_mul  = mul_q.size();
        b_add  = add_q.size();
        b_done = done_cnt;
        b_busy = busy_cnt;
        n_v    = DW'(n);
        if (m > 0 && n > 0 && k > 0) begin
            for (int r = 0; r < m; r += RT)
                for (int c = 0; c < n; c += CT)
                    for (int kk = 0; kk < k; kk += IT) begin
                        r_v = DW'(r);
                        c_v = DW'(c);
                        k_v = DW'(kk);
                        em.push_back({r_v, c_v, k_v});
                        ea.push_back({r_v, c_v, n_v});
                    end
        end
        slices     = em.size();
        w          = hold ? 1 : d;
        resp_delay = d;
        resp_hold  = hold;

        m_rows  = DW'(m);
        n_cols  = DW'(n);
        k_inner = DW'(k);
        start   = 1'b1;
        tick;
        start   = 1'b0;
        m_rows  = DW'($urandom);
        n_cols  = DW'($urandom);
        k_inner = DW'($urandom);
        guard   = 0;
        while (done_cnt == b_done && guard < 5000) begin
            start = poke && (guard % 3 == 0);
            tick;
            guard++;
        end
        start = 1'b0;
        repeat (3) tick;
        resp_hold = 1'b0;

        check({name, " done_count"}, done_cnt - b_done, 1);
        check({name, " mul_count"}, mul_q.size() - b_mul, slices);
        check({name, " add_count"}, add_q.size() - b_add, slices);
        for (int i = 0; i < slices; i++) begin
            obs = (b_mul + i < mul_q.size()) ? mul_q[b_mul + i] : 'x;
            check($sformatf("%s mul_slice%0d", name, i), obs, em[i]);
            obs = (b_add + i < add_q.size()) ? add_q[b_add + i] : 'x;
            check($sformatf("%s add_slice%0d", name, i), obs, ea[i]);
        end
        check({name, " busy_cycles"}, busy_cnt - b_busy, slices * (3 + w) + 2);
        check({name, " done_latency"}, done_idx - start_idx, slices * (3 + w) + 1);
        check({name, " busy_after"}, busy, 0);
`ifdef BLOCK_SCHED_PERF_EN
        check({name, " perf_cycles"}, perf_cycles, slices * (3 + w) + 2);
        check({name, " perf_stall"}, perf_stall, slices * (w - 1));
`endif
    endtask

    int b_mul_rst;
    int b_add_rst;
    int guard_rst;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        m_rows   = '0;
        n_cols   = '0;
        k_inner  = '0;
        mul_done = 1'b0;
        repeat (2) tick;
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset pulses", {done, mul_start, add_start}, 0);
        check("reset coords", {mul_row, mul_col, mul_k, add_row, add_col, add_num_cols}, 0);
        tick;
        rst = 1'b0;
        repeat (2) tick;

        run("mnk4", 4, 4, 4, 2, 1'b0, 1'b0);
        run("m3n2k2", 3, 2, 2, 2, 1'b0, 1'b0);
        run("kzero", 3, 3, 0, 2, 1'b0, 1'b0);
        run("hold_poke", 4, 4, 4, 1, 1'b1, 1'b1);
        run("one_slice", 2, 2, 2, 3, 1'b0, 1'b0);

        // Abort in WAIT_MUL of the third slice, then rerun from scratch.
        b_mul_rst  = mul_q.size();
        b_add_rst  = add_q.size();
        resp_delay = 4;
        m_rows  = 10'd4;
        n_cols  = 10'd4;
        k_inner = 10'd4;
        start   = 1'b1;
        tick;
        start     = 1'b0;
        guard_rst = 0;
        while (mul_q.size() - b_mul_rst < 3 && guard_rst < 200) begin
            tick;
            guard_rst++;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst busy", busy, 0);
        check("midrst pulses", {done, mul_start, add_start}, 0);
        check("midrst coords", {mul_row, mul_col, mul_k, add_row, add_col, add_num_cols}, 0);
        tick;
        rst = 1'b0;
        repeat (6) tick;
        check("midrst mul_after", mul_q.size() - b_mul_rst, 3);
        check("midrst add_after", add_q.size() - b_add_rst, 2);
        run("rerun", 4, 4, 4, 2, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run($sformatf("rand%0d", i), $urandom_range(1, 7), $urandom_range(1, 7),
                $urandom_range(1, 7), $urandom_range(1, 4), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
